// File: rtl/muacm_in_arb.sv
// muacm_in_arb: two-source, packet-granular round-robin arbiter in front of
// the muacm IN pipe (device-to-host byte stream).
//
// A grant is held until the owner ends its packet, reaches MAX_BURST bytes,
// or stays idle for IDLE_TIMEOUT granted cycles.
// At least one IDLE cycle separates consecutive grants.
//
// Build option: define MUACM_ARB_FLUSH_EN to insert a one-cycle FLUSH state
// (in_flush_now pulse) after burst-cut or timeout releases. Without it the
// FLUSH state does not exist and in_flush_now is tied low.

module muacm_in_arb #(
    parameter int MAX_BURST    = 64,  // 1..1024 bytes per grant
    parameter int IDLE_TIMEOUT = 16   // 0 disables the idle timeout
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic [7:0] s0_data,
    input  logic       s0_last,
    input  logic       s0_valid,
    output logic       s0_ready,

    input  logic [7:0] s1_data,
    input  logic       s1_last,
    input  logic       s1_valid,
    output logic       s1_ready,

    output logic [7:0] in_data,
    output logic       in_last,
    output logic       in_valid,
    input  logic       in_ready,
    output logic       in_flush_now,
    output logic       in_flush_time,

    output logic [1:0] grant
);

    // Byte counter must be able to hold MAX_BURST itself.
    localparam int CW = $clog2(MAX_BURST + 1);
    // Idle counter needs at least one bit even when the timeout is disabled.
    localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN = (IDLE_TIMEOUT != 0);

`ifdef MUACM_ARB_FLUSH_EN
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_FLUSH} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT} state_t;
`endif

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    // Round-robin pointer: 0 prefers s0, 1 prefers s1 when both request.
    logic            rr_q, rr_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

    logic            owner_valid;
    logic            owner_last;
    logic [7:0]      owner_data;
    logic            xfer;
    logic [CW-1:0]   byte_cnt_inc;
    logic [IW-1:0]   idle_cnt_inc;
    logic            rel_last;
    logic            rel_burst;
    logic            rel_idle;
    logic            release_now;

    // Owner mux: grant_q is only non-zero in GRANT, so it alone gates the path.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = 8'h00;
        if (grant_q[0]) begin
            owner_valid = s0_valid;
            owner_last  = s0_last;
            owner_data  = s0_data;
        end else if (grant_q[1]) begin
            owner_valid = s1_valid;
            owner_last  = s1_last;
            owner_data  = s1_data;
        end
    end

    // Release conditions for the current cycle, acted on at the next edge.
    always_comb begin
        xfer         = owner_valid & in_ready;
        byte_cnt_inc = byte_cnt_q + 1'b1;
        idle_cnt_inc = idle_cnt_q + 1'b1;
        rel_last     = xfer & owner_last;
        rel_burst    = xfer & (byte_cnt_inc == CW'(MAX_BURST));
        rel_idle     = TIMEOUT_EN & (grant_q != 2'b00) & ~owner_valid &
                       (idle_cnt_inc == IW'(IDLE_TIMEOUT));
        release_now  = rel_last | rel_burst | rel_idle;
    end

    // Pipe-facing outputs: zero-latency pass-through of the current owner.
    always_comb begin
        in_data       = owner_data;
        in_last       = owner_last;
        in_valid      = owner_valid;
        s0_ready      = grant_q[0] & in_ready;
        s1_ready      = grant_q[1] & in_ready;
        in_flush_time = (state_q == ST_IDLE);
        grant         = grant_q;
`ifdef MUACM_ARB_FLUSH_EN
        in_flush_now  = (state_q == ST_FLUSH);
`else
        in_flush_now  = 1'b0;
`endif
    end

    // Next-state logic: arbitration in IDLE, counting and release in GRANT.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;

        case (state_q)
            ST_IDLE: begin
                byte_cnt_d = '0;
                idle_cnt_d = '0;
                if (s0_valid || s1_valid) begin
                    state_d = ST_GRANT;
                    if (s0_valid && s1_valid) begin
                        grant_d = rr_q ? 2'b10 : 2'b01;
                    end else if (s0_valid) begin
                        grant_d = 2'b01;
                    end else begin
                        grant_d = 2'b10;
                    end
                end
            end

            ST_GRANT: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_inc;
                end
                // Owner may pause mid-packet; only a sustained pause releases.
                if (owner_valid) begin
                    idle_cnt_d = '0;
                end else if (TIMEOUT_EN) begin
                    idle_cnt_d = idle_cnt_inc;
                end

                if (release_now) begin
                    // Prefer the other source next time both request.
                    rr_d       = grant_q[0];
                    grant_d    = 2'b00;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
`ifdef MUACM_ARB_FLUSH_EN
                    // A packet end already closes the muacm packet; only
                    // burst cuts and timeouts need an explicit flush.
                    if (!rel_last) begin
                        state_d = ST_FLUSH;
                    end
`endif
                end
            end

`ifdef MUACM_ARB_FLUSH_EN
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
`endif

            default: begin
                state_d    = ST_IDLE;
                grant_d    = 2'b00;
                byte_cnt_d = '0;
                idle_cnt_d = '0;
            end
        endcase
    end

    // State registers; async reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            rr_q       <= 1'b0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_muacm_in_arb.sv
// Scoreboard bench for muacm_in_arb: per-source expected byte queues are
// filled as stimulus is queued; a negedge monitor pops and compares every
// transfer on in_*. Directed grant/flush sequences are checked inline.
// Instance 0 uses default parameters, instance 1 uses MAX_BURST = 4.

module tb_muacm_in_arb;

    logic       clk;
    logic       rst_n;

    // Source index k = inst*2 + src.
    logic [7:0] sd  [4];
    logic       sl  [4];
    logic       sv  [4];
    logic       sr  [4];

    logic [7:0] idat  [2];
    logic       ilast [2];
    logic       ival  [2];
    logic       irdy  [2];
    logic       ifn   [2];
    logic       ift   [2];
    logic [1:0] gnt   [2];

    logic [8:0] srcq [4][$];   // {last, data} waiting to be driven
    logic [8:0] exq  [4][$];   // {last, data} expected on in_*
    logic       hs   [4];

    int n_chk;
    int n_fail;

`ifdef MUACM_ARB_FLUSH_EN
    localparam int FL = 1;
    localparam int N3 = 17;
    int g3 [N3] = '{1, 1, 1, 1, 0, 0, 2, 2, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    int f3 [N3] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
`else
    localparam int FL = 0;
    localparam int N3 = 15;
    int g3 [N3] = '{1, 1, 1, 1, 0, 2, 2, 0, 1, 1, 1, 1, 0, 1, 1};
    int f3 [N3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    int g2 [16] = '{1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 0, 2, 2, 2, 0};

    muacm_in_arb u_dut (
        .clk(clk), .rst_n(rst_n),
        .s0_data(sd[0]), .s0_last(sl[0]), .s0_valid(sv[0]), .s0_ready(sr[0]),
        .s1_data(sd[1]), .s1_last(sl[1]), .s1_valid(sv[1]), .s1_ready(sr[1]),
        .in_data(idat[0]), .in_last(ilast[0]), .in_valid(ival[0]), .in_ready(irdy[0]),
        .in_flush_now(ifn[0]), .in_flush_time(ift[0]), .grant(gnt[0])
    );

    muacm_in_arb #(.MAX_BURST(4), .IDLE_TIMEOUT(16)) u_bst (
        .clk(clk), .rst_n(rst_n),
        .s0_data(sd[2]), .s0_last(sl[2]), .s0_valid(sv[2]), .s0_ready(sr[2]),
        .s1_data(sd[3]), .s1_last(sl[3]), .s1_valid(sv[3]), .s1_ready(sr[3]),
        .in_data(idat[1]), .in_last(ilast[1]), .in_valid(ival[1]), .in_ready(irdy[1]),
        .in_flush_now(ifn[1]), .in_flush_time(ift[1]), .grant(gnt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        srcq[k].push_back({l, d});
        exq[k].push_back({l, d});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Source driver: pops accepted bytes, then presents the next queued byte.
    initial begin
        for (int k = 0; k < 4; k++) begin
            sv[k] = 1'b0;
            sd[k] = 8'h00;
            sl[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) hs[k] = sv[k] && sr[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (hs[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
                if (srcq[k].size() > 0) begin
                    sv[k] = 1'b1;
                    sd[k] = srcq[k][0][7:0];
                    sl[k] = srcq[k][0][8];
                end else begin
                    sv[k] = 1'b0;
                    sd[k] = 8'h00;
                    sl[k] = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted byte must come from the granted source, in order.
    always @(negedge clk) begin : mon
        int k;
        logic [8:0] e;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (ival[i] && irdy[i]) begin
                    k = (gnt[i] == 2'b01) ? 2 * i : (gnt[i] == 2'b10) ? 2 * i + 1 : -1;
                    if (k < 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL xfer_owner inst%0d: grant %b, expected one-hot", i, gnt[i]);
                    end else if (exq[k].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL xfer_unexpected inst%0d: byte 0x%0h, expected none", i, idat[i]);
                    end else begin
                        e = exq[k].pop_front();
                        chk("xfer_last_data", int'({ilast[i], idat[i]}), int'(e));
                        chk("nonowner_ready", int'(sr[k ^ 1]), 0);
                    end
                end
            end
        end
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        irdy[0] = 1'b1;
        irdy[1] = 1'b1;
        tick();
        tick();

        // Reset state of both instances
        for (int i = 0; i < 2; i++) begin
            chk("rst_grant", int'(gnt[i]), 0);
            chk("rst_in_valid", int'(ival[i]), 0);
            chk("rst_s0_ready", int'(sr[2 * i]), 0);
            chk("rst_s1_ready", int'(sr[2 * i + 1]), 0);
            chk("rst_in_last", int'(ilast[i]), 0);
            chk("rst_in_data", int'(idat[i]), 0);
            chk("rst_flush_now", int'(ifn[i]), 0);
            chk("rst_flush_time", int'(ift[i]), 1);
        end
        rst_n = 1'b1;
        tick();

        // Test 1: single s0 packet 0x10..0x14
        for (int b = 0; b < 5; b++) push(0, 8'(16 + b), b == 4);
        tick();
        chk("t1_no_grant_yet", int'(gnt[0]), 0);
        chk("t1_flush_time_idle", int'(ift[0]), 1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("t1_grant_held", int'(gnt[0]), 1);
            chk("t1_s1_ready", int'(sr[1]), 0);
            chk("t1_flush_time_grant", int'(ift[0]), 0);
        end
        tick();
        chk("t1_grant_released", int'(gnt[0]), 0);
        chk("t1_all_bytes", exq[0].size(), 0);

        // Test 2: both sources, two 3-byte packets each
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 3; b++) begin
                push(0, 8'(32 + p * 3 + b), b == 2);
                push(1, 8'(176 + p * 3 + b), b == 2);
            end
        end
        tick();
        for (int c = 0; c < 16; c++) begin
            tick();
            chk("t2_grant_seq", int'(gnt[0]), g2[c]);
        end
        chk("t2_s0_bytes", exq[0].size(), 0);
        chk("t2_s1_bytes", exq[1].size(), 0);

        // Test 3: MAX_BURST = 4, s0 streams 10 bytes, s1 waiting
        do_reset();
        for (int b = 0; b < 10; b++) push(2, 8'(48 + b), 1'b0);
        push(3, 8'hA0, 1'b0);
        push(3, 8'hA1, 1'b1);
        tick();
        for (int c = 0; c < N3; c++) begin
            tick();
            chk("t3_grant_seq", int'(gnt[1]), g3[c]);
            chk("t3_flush_now", int'(ifn[1]), f3[c]);
        end
        repeat (25) tick();
        chk("t3_final_grant", int'(gnt[1]), 0);
        chk("t3_s0_bytes", exq[2].size(), 0);
        chk("t3_s1_bytes", exq[3].size(), 0);

        // Test 4: idle timeout after s0 drops valid
        do_reset();
        push(0, 8'h40, 1'b0);
        push(0, 8'h41, 1'b0);
        tick();
        tick();
        tick();
        tick();
        chk("t4_valid_dropped", int'(ival[0]), 0);
        chk("t4_grant_kept", int'(gnt[0]), 1);
        repeat (15) tick();
        chk("t4_grant_at_15", int'(gnt[0]), 1);
        chk("t4_no_flush_yet", int'(ifn[0]), 0);
        tick();
        chk("t4_grant_timeout", int'(gnt[0]), 0);
        chk("t4_flush_pulse", int'(ifn[0]), FL);
        tick();
        chk("t4_flush_end", int'(ifn[0]), 0);
        chk("t4_bytes", exq[0].size(), 0);

        // Test 5: in_ready held low for 20 cycles during an s0 grant
        do_reset();
        irdy[0] = 1'b0;
        push(0, 8'h50, 1'b0);
        push(0, 8'h51, 1'b1);
        tick();
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t5_hold", int'({gnt[0], sr[0], ival[0], idat[0]}),
                int'({2'b01, 1'b0, 1'b1, 8'h50}));
        end
        irdy[0] = 1'b1;
        tick();
        tick();
        chk("t5_released", int'(gnt[0]), 0);
        chk("t5_bytes", exq[0].size(), 0);

        // Test 6: async reset in the middle of an s1 packet
        do_reset();
        for (int b = 0; b < 4; b++) push(1, 8'(96 + b), b == 3);
        tick();
        tick();
        tick();
        chk("t6_s1_granted", int'(gnt[0]), 2);
        rst_n = 1'b0;
        #1;
        chk("t6_async_in_valid", int'(ival[0]), 0);
        chk("t6_async_s1_ready", int'(sr[1]), 0);
        chk("t6_async_grant", int'(gnt[0]), 0);
        push(0, 8'h70, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_first_is_s0", int'(gnt[0]), 1);
        tick();
        chk("t6_gap", int'(gnt[0]), 0);
        tick();
        chk("t6_then_s1", int'(gnt[0]), 2);
        repeat (3) tick();
        chk("t6_s1_done", int'(gnt[0]), 0);
        chk("t6_s0_bytes", exq[0].size(), 0);
        chk("t6_s1_bytes", exq[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muacm_in_arb.md
Name: muacm_in_arb

Overview:
- Two-source arbiter that shares the single muacm IN pipe (device-to-host byte stream) between two requesters, e.g. a loopback path and a local status/log source.
- Grants are held for a whole packet, so one source's bytes are never interleaved with the other's.
- Round-robin selection between sources; fairness is bounded by a burst limit and an idle timeout.
- Sits between the requesters and the muacm in_* port group, in the muacm clock domain.

Parameters:
- MAX_BURST, 64: maximum bytes transferred per grant before forced release; legal range 1..1024.
- IDLE_TIMEOUT, 16: consecutive granted cycles with source valid low before forced release; 0 disables the timeout.

Ports:
- clk  in  1  system clock (muacm domain)
- rst_n  in  1  asynchronous active-low reset
- s0_data  in  8  source 0 byte
- s0_last  in  1  source 0 end-of-packet marker
- s0_valid  in  1  source 0 byte valid
- s0_ready  out  1  source 0 byte accepted
- s1_data  in  8  source 1 byte
- s1_last  in  1  source 1 end-of-packet marker
- s1_valid  in  1  source 1 byte valid
- s1_ready  out  1  source 1 byte accepted
- in_data  out  8  to muacm in_data
- in_last  out  1  to muacm in_last
- in_valid  out  1  to muacm in_valid
- in_ready  in  1  from muacm in_ready
- in_flush_now  out  1  to muacm in_flush_now
- in_flush_time  out  1  to muacm in_flush_time
- grant  out  2  one-hot current owner (bit0 = s0, bit1 = s1); 00 means none

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, grant = 00, round-robin pointer favours s0, byte and idle counters = 0.
  - All outputs driven 0: in_valid, s0_ready, s1_ready, in_last, in_flush_now, in_data = 0.
- Reset mid-packet: the grant is dropped immediately; no bytes are transferred until rst_n deasserts.
- IDLE state:
  - in_valid = 0, both s*_ready = 0, in_flush_time = 1.
  - If any s*_valid is high, register a grant and go to GRANT on the next edge.
  - Only one requester valid: that source wins.
  - Both valid: the source not granted last wins. The first arbitration after reset picks s0.
- Arbitration latency: 1 cycle from s*_valid rising in IDLE to in_valid possible.
- GRANT state, datapath is combinational and zero-latency through the owner:
  - in_data / in_last / in_valid = owner's data / last / valid.
  - owner_ready = in_ready; the non-owner's ready = 0.
  - in_flush_time = 0.
- A transfer occurs on a cycle with in_valid & in_ready. The byte counter increments on each transfer; counter width is clog2(MAX_BURST+1).
- Idle counter: increments each GRANT cycle with owner valid low; clears on any cycle with owner valid high. The owner may drop valid mid-packet without losing the grant, subject to the timeout.
- Release conditions, evaluated on the clock edge:
  - (a) a transfer with last = 1;
  - (b) a transfer that brings the byte count to MAX_BURST;
  - (c) IDLE_TIMEOUT != 0 and the idle counter reaches IDLE_TIMEOUT.
- On release:
  - Record the owner in the round-robin pointer, clear both counters, and set grant = 00.
  - The next state is IDLE, or FLUSH (see Optional Feature).
- Simultaneous (a) and (b) on the same transfer: treated as one release.
- No back-to-back grants: at least one IDLE cycle separates consecutive grants, so sustained throughput with two active sources is ≤ MAX_BURST/(MAX_BURST+1).
- in_last is forwarded unmodified; a burst cut (b) does not force in_last.

Optional Feature:
- Macro: MUACM_ARB_FLUSH_EN.
- Defined:
  - A release via (b) or (c) goes to state FLUSH. FLUSH asserts in_flush_now = 1 for exactly one cycle, with in_valid = 0 and both readies 0, then returns to IDLE.
  - A release via (a) skips FLUSH, because muacm already terminates the packet on in_last.
- Not defined: the FLUSH state does not exist, in_flush_now is constant 0, and every release goes directly to IDLE.

Test Plan:
- Reset, then s0 presents 5 bytes 0x10..0x14 with last on 0x14, in_ready = 1 → grant = 01 one cycle after valid; 5 transfers on in_data in order; grant = 00 the cycle after 0x14; s1_ready stays 0 throughout.
- s0 and s1 both valid from the same cycle after reset, each sending 3-byte packets (last on the third byte), repeated twice → grant order s0, s1, s0, s1; one idle cycle between grants; no interleaved bytes.
- MAX_BURST = 4, s0 streams 10 bytes with no last while s1 is valid → s0 loses the grant after 4 bytes; s1 is then granted; s0 resumes at byte 5 on its next grant. With MUACM_ARB_FLUSH_EN, a one-cycle in_flush_now pulse follows the 4th byte.
- IDLE_TIMEOUT = 16, s0 sends 2 bytes and then holds valid low → grant released exactly 16 cycles after valid drops. With the macro, in_flush_now pulses once; without it, in_flush_now stays 0.
- in_ready held 0 for 20 cycles during an s0 grant with s0 valid high → grant held, no timeout, s0_ready = 0, data stable; the transfer completes when in_ready rises.
- rst_n asserted mid-packet of s1 → in_valid, s1_ready and grant go to 0 asynchronously; after release, the first simultaneous request goes to s0.
